// File: rtl/full_adder_cell_slice.sv
// -----------------------------------------------------------------------------
// fa_slice: single-bit combinational full adder.
//
// Ports:
//   cout - carry-out, majority of (a, b, cin)
//   sum  - sum bit, a ^ b ^ cin
//   a    - addend bit
//   b    - addend bit
//   cin  - carry-in bit
// -----------------------------------------------------------------------------
module fa_slice (
  output logic cout,
  output logic sum,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  // Carry is set whenever at least two of the three inputs are set.
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell: bank of WIDTH independent 1-bit full adders with an
// optional one-cycle registered copy of the results.
//
// Slices never interact; a parent that wants a ripple adder chains cout of
// one instance into cin of the next. With WIDTH=1 the combinational ports
// are a drop-in for the classic (cout, sum, a, b, cin) cell.
//
// Ports:
//   clk       - rising-edge clock for the registered stage
//   rst       - synchronous active-high reset of the registered stage
//   cout      - combinational carry-out per slice   [WIDTH]
//   sum       - combinational sum per slice         [WIDTH]
//   a, b      - addend bits per slice               [WIDTH]
//   cin       - carry-in per slice                  [WIDTH]
//   in_valid  - capture strobe for the registered stage
//   sum_q     - registered sum                      [WIDTH]
//   cout_q    - registered carry-out                [WIDTH]
//   out_valid - high for one cycle after each capture
// -----------------------------------------------------------------------------
module full_adder_cell #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] cout,
  output logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] cout_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] cout_d;
  logic             valid_d;

  // One independent full adder per bit position.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
    fa_slice u_fa (
      .cout (cout[gi]),
      .sum  (sum[gi]),
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (cin[gi])
    );
  end

  // Next-state for the registered stage: capture on in_valid, otherwise hold
  // data and drop the valid flag so it only marks freshly captured results.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = sum;
      cout_d  = cout;
      valid_d = 1'b1;
    end else begin
      sum_d   = sum_q;
      cout_d  = cout_q;
      valid_d = 1'b0;
    end
  end

  // Registered stage; reset wins over a simultaneous capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= {WIDTH{1'b0}};
      cout_q    <= {WIDTH{1'b0}};
      out_valid <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      out_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_full_adder_cell.sv
module tb_full_adder_cell;

  logic       clk = 1'b0;
  logic       rst;
  int         errors = 0;
  int         checks = 0;

  // WIDTH=8 main DUT
  logic [7:0] a, b, cin;
  logic       in_valid;
  logic [7:0] sum, cout, sum_q, cout_q;
  logic       out_valid;

  // WIDTH=1 DUT for the exhaustive truth table
  logic [0:0] a1, b1, c1;
  logic [0:0] s1, co1, s1_q, co1_q;
  logic       ov1;

  // Chained WIDTH=1 instances forming an 8-bit subtractor a - b
  logic [7:0] ch_a, ch_b, ch_bn, ch_d, ch_sq, ch_cq;
  logic [7:0] ch_ov;
  logic [8:0] ch_c;

  always #5 clk = ~clk;

  full_adder_cell #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cout(cout), .sum(sum), .a(a), .b(b), .cin(cin),
    .in_valid(in_valid), .sum_q(sum_q), .cout_q(cout_q), .out_valid(out_valid)
  );

  full_adder_cell #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .cout(co1), .sum(s1), .a(a1), .b(b1), .cin(c1),
    .in_valid(1'b0), .sum_q(s1_q), .cout_q(co1_q), .out_valid(ov1)
  );

  assign ch_bn   = ~ch_b;
  assign ch_c[0] = 1'b1;
  for (genvar gi = 0; gi < 8; gi++) begin : g_chain
    full_adder_cell #(.WIDTH(1)) u_ch (
      .clk(clk), .rst(rst), .cout(ch_c[gi+1]), .sum(ch_d[gi]),
      .a(ch_a[gi]), .b(ch_bn[gi]), .cin(ch_c[gi]),
      .in_valid(1'b0), .sum_q(ch_sq[gi]), .cout_q(ch_cq[gi]), .out_valid(ch_ov[gi])
    );
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Per-slice truth table {cout,sum} indexed by {a,b,cin}
  logic [1:0] tt [8];

  initial begin
    tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b01; tt[3] = 2'b10;
    tt[4] = 2'b01; tt[5] = 2'b10; tt[6] = 2'b10; tt[7] = 2'b11;

    rst = 1'b1; in_valid = 1'b0;
    a = 8'h00; b = 8'h00; cin = 8'h00;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    ch_a = 8'h00; ch_b = 8'h00;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_sum_q", sum_q, 8'h00);
    check("rst_cout_q", cout_q, 8'h00);
    check("rst_out_valid", {7'd0, out_valid}, 8'h00);
    check("rst_ov1", {7'd0, ov1}, 8'h00);

    @(negedge clk); rst = 1'b0;

    // Exhaustive WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; c1 = v[0];
      #1;
      check($sformatf("tt%0d", i), {6'd0, co1, s1}, {6'd0, tt[i]});
    end

    // Registered latency, WIDTH=8
    @(negedge clk);
    a = 8'hF0; b = 8'hF0; cin = 8'h00; in_valid = 1'b1;
    #1;
    check("lat_comb_sum", sum, 8'h00);
    check("lat_comb_cout", cout, 8'hF0);
    @(posedge clk); #1;
    check("lat_sum_q", sum_q, 8'h00);
    check("lat_cout_q", cout_q, 8'hF0);
    check("lat_ov", {7'd0, out_valid}, 8'h01);
    @(negedge clk); in_valid = 1'b0; a = 8'h11; b = 8'h22; cin = 8'h44;
    @(posedge clk); #1;
    check("lat_ov_drop", {7'd0, out_valid}, 8'h00);
    check("lat_sum_hold", sum_q, 8'h00);
    check("lat_cout_hold", cout_q, 8'hF0);

    // Reset wins over capture; combinational path unaffected
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 8'hFF;
    #1;
    check("rst_comb_sum", sum, 8'hFF);
    check("rst_comb_cout", cout, 8'hFF);
    @(posedge clk); #1;
    check("rstmid_sum_q", sum_q, 8'h00);
    check("rstmid_cout_q", cout_q, 8'h00);
    check("rstmid_ov", {7'd0, out_valid}, 8'h00);

    // First edge after reset captures; then hold while inputs change
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; a = 8'h0F; b = 8'h00; cin = 8'h00;
    @(posedge clk); #1;
    check("hold_cap_sum_q", sum_q, 8'h0F);
    check("hold_cap_cout_q", cout_q, 8'h00);
    check("hold_cap_ov", {7'd0, out_valid}, 8'h01);
    @(negedge clk); in_valid = 1'b0; a = 8'hAA; b = 8'h55; cin = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_sum_q", sum_q, 8'h0F);
    check("hold_cout_q", cout_q, 8'h00);
    check("hold_ov", {7'd0, out_valid}, 8'h00);

    // Chained subtractor a - b
    ch_a = 8'hF0; ch_b = 8'hF0; #1;
    check("chain_f0_diff", ch_d, 8'h00);
    check("chain_f0_carry", {7'd0, ch_c[8]}, 8'h01);
    ch_a = 8'hFF; ch_b = 8'hFF; #1;
    check("chain_ff_diff", ch_d, 8'h00);
    check("chain_ff_carry", {7'd0, ch_c[8]}, 8'h01);
    ch_a = 8'h05; ch_b = 8'h03; #1;
    check("chain_5m3_diff", ch_d, 8'h02);
    check("chain_5m3_carry", {7'd0, ch_c[8]}, 8'h01);
    ch_a = 8'h03; ch_b = 8'h05; #1;
    check("chain_3m5_diff", ch_d, 8'hFE);
    check("chain_3m5_carry", {7'd0, ch_c[8]}, 8'h00);

    // Back-to-back captures
    @(negedge clk);
    a = 8'h3C; b = 8'hA5; cin = 8'h0F; in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b1_sum_q", sum_q, 8'h96);
    check("b2b1_cout_q", cout_q, 8'h2D);
    check("b2b1_ov", {7'd0, out_valid}, 8'h01);
    @(negedge clk);
    a = 8'hFF; b = 8'h01; cin = 8'h00;
    @(posedge clk); #1;
    check("b2b2_sum_q", sum_q, 8'hFE);
    check("b2b2_cout_q", cout_q, 8'h01);
    check("b2b2_ov", {7'd0, out_valid}, 8'h01);
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 8'h56;
    @(posedge clk); #1;
    check("b2b3_sum_q", sum_q, 8'h70);
    check("b2b3_cout_q", cout_q, 8'h16);
    check("b2b3_ov", {7'd0, out_valid}, 8'h01);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_end_ov", {7'd0, out_valid}, 8'h00);
    check("b2b_end_sum_q", sum_q, 8'h70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
